// File: rtl/spdif_tx_pkg.sv
// S/PDIF transmit constants: preambles, block/frame geometry, subframe slot map, channel-status word.
// Shared by the encoder and the top; no logic state.
package spdif_tx_pkg;

    localparam logic [7:0] SPDIF_PRE_B = 8'b1110_1000;
    localparam logic [7:0] SPDIF_PRE_M = 8'b1110_0010;
    localparam logic [7:0] SPDIF_PRE_W = 8'b1110_0100;

    localparam int SPDIF_FRAMES_PER_BLOCK = 192;
    localparam int SPDIF_CELLS_PER_FRAME  = 128;

    localparam logic [4:0] SLOT_DATA_LO = 5'd4;
    localparam logic [4:0] SLOT_DATA_HI = 5'd27;
    localparam logic [4:0] SLOT_V       = 5'd28;
    localparam logic [4:0] SLOT_U       = 5'd29;
    localparam logic [4:0] SLOT_C       = 5'd30;
    localparam logic [4:0] SLOT_P       = 5'd31;

    localparam logic [3:0] CS_WORDLEN_24 = 4'b1011;

    // Consumer-format channel-status word, one bit per frame of the block.
    function automatic logic chstat_bit(input logic [7:0] idx, input logic [3:0] fs);
        logic b;
        b = 1'b0;
        if (idx == 8'd2)
            b = 1'b1;
        else if (idx >= 8'd24 && idx <= 8'd27)
            b = fs[idx[1:0]];
        else if (idx >= 8'd32 && idx <= 8'd35)
            b = CS_WORDLEN_24[idx[1:0]];
        return b;
    endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark cell level generator: next line level from previous level and slot bit or preamble cell.
// Latency: combinational. Backpressure: none.
// Mid-slot toggle only for a one bit; preamble cells are taken verbatim, inverted by the pre-preamble level.
module spdif_bmc_enc (
    input  logic prev,
    input  logic is_pre,
    input  logic pre_bit,
    input  logic pre_base,
    input  logic half,
    input  logic slot_bit,
    output logic level
);

    always_comb begin
        level = ~prev;
        if (is_pre)
            level = pre_bit ^ pre_base;
        else if (half)
            level = slot_bit ? ~prev : prev;
    end

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF transmitter: 24-bit stereo pairs to biphase-mark line, 192-frame blocks. SPDIF_TX_CHSTAT_EN adds C bits.
// Latency: pair accepted at end of frame is sent from cell 0 of the next frame (right 64 cells later).
// Backpressure: one-cycle sample_ready per frame; missing pair sends zeros with V=1 and pulses underrun.
module spdif_tx
    import spdif_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        ena,
    input  logic [23:0] sample_l,
    input  logic [23:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [3:0]  cs_fs,
    output logic        tx_out,
    output logic [7:0]  frame_cnt,
    output logic        underrun
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [6:0] LAST_CELL  = 7'(SPDIF_CELLS_PER_FRAME - 1);
    localparam logic [7:0] LAST_FRAME = 8'(SPDIF_FRAMES_PER_BLOCK - 1);

    logic [DW-1:0] div_cnt;
    logic [6:0]    cell_cnt;
    logic          running;
    logic          pre_base;
    logic          parity;
    logic          v_bit;
    logic [23:0]   hold_l;
    logic [23:0]   hold_r;

    logic          tick;
    logic [6:0]    next_cell;
    logic [7:0]    next_frame;
    logic [4:0]    slot;
    logic          is_pre;
    logic [7:0]    pre_pat;
    logic          base;
    logic [23:0]   data;
    logic          c_bit;
    logic          slot_bit;
    logic          level;

    assign tick         = ena && (div_cnt == DW'(CLK_DIV - 1));
    assign sample_ready = tick && (!running || cell_cnt == LAST_CELL);
    assign underrun     = sample_ready && !sample_valid;

    // Everything below describes the cell that goes on the line at this tick.
    assign next_cell  = running ? cell_cnt + 7'd1 : 7'd0;
    assign next_frame = !running ? 8'd0 :
                        (cell_cnt != LAST_CELL) ? frame_cnt :
                        (frame_cnt == LAST_FRAME) ? 8'd0 : frame_cnt + 8'd1;
    assign slot     = next_cell[5:1];
    assign is_pre   = (next_cell[5:3] == 3'b000);
    assign pre_pat  = next_cell[6] ? SPDIF_PRE_W :
                      (next_frame == 8'd0) ? SPDIF_PRE_B : SPDIF_PRE_M;
    assign base     = (next_cell[5:0] == 6'd0) ? tx_out : pre_base;
    assign data     = next_cell[6] ? hold_r : hold_l;

`ifdef SPDIF_TX_CHSTAT_EN
    logic [3:0] cs_fs_q;
    assign c_bit = chstat_bit(frame_cnt, cs_fs_q);
`else
    logic unused_cs_fs;
    assign unused_cs_fs = ^cs_fs;
    assign c_bit        = 1'b0;
`endif

    always_comb begin
        slot_bit = 1'b0;
        if (slot >= SLOT_DATA_LO && slot <= SLOT_DATA_HI)
            slot_bit = data[slot - SLOT_DATA_LO];
        else if (slot == SLOT_V)
            slot_bit = v_bit;
        else if (slot == SLOT_U)
            slot_bit = 1'b0;
        else if (slot == SLOT_C)
            slot_bit = c_bit;
        else if (slot == SLOT_P)
            slot_bit = parity;
    end

    spdif_bmc_enc u_enc (
        .prev     (tx_out),
        .is_pre   (is_pre),
        .pre_bit  (pre_pat[~next_cell[2:0]]),
        .pre_base (base),
        .half     (next_cell[0]),
        .slot_bit (slot_bit),
        .level    (level)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            div_cnt   <= '0;
            cell_cnt  <= '0;
            frame_cnt <= '0;
            running   <= 1'b0;
            tx_out    <= 1'b0;
            pre_base  <= 1'b0;
            parity    <= 1'b0;
            v_bit     <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
`ifdef SPDIF_TX_CHSTAT_EN
            cs_fs_q   <= '0;
`endif
        end else if (!ena) begin
            div_cnt   <= '0;
            cell_cnt  <= '0;
            frame_cnt <= '0;
            running   <= 1'b0;
            tx_out    <= 1'b0;
            pre_base  <= 1'b0;
            parity    <= 1'b0;
            v_bit     <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
`ifdef SPDIF_TX_CHSTAT_EN
            cs_fs_q   <= '0;
`endif
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                running   <= 1'b1;
                cell_cnt  <= next_cell;
                frame_cnt <= next_frame;
                tx_out    <= level;
                if (next_cell[5:0] == 6'd0) begin
                    pre_base <= tx_out;
                    parity   <= 1'b0;
                end else if (!next_cell[0] && slot >= SLOT_DATA_LO && slot <= SLOT_C) begin
                    parity <= parity ^ slot_bit;
                end
                if (sample_ready) begin
                    hold_l <= sample_valid ? sample_l : 24'd0;
                    hold_r <= sample_valid ? sample_r : 24'd0;
                    v_bit  <= !sample_valid;
                end
`ifdef SPDIF_TX_CHSTAT_EN
                if (next_cell == 7'd0 && next_frame == 8'd0)
                    cs_fs_q <= cs_fs;
`endif
            end
        end
    end

endmodule

// File: tb/tb_spdif_tx.sv
// Bench for spdif_tx: decodes every transmitted frame and checks it against the pair queued at accept time.
// Covers reset/idle, handshake, underrun, preamble sequence over a full block, ena abort and restart.
module tb_spdif_tx;

    localparam int CLK_DIV = 2;
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        v;
        logic [7:0]  frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetb;
    logic        ena;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  cs_fs;
    logic        tx_out;
    logic [7:0]  frame_cnt;
    logic        underrun;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    int          model_frame;
    logic        last_lvl;
    logic [127:0] cells;

    always #5 clk = ~clk;

    spdif_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .ena          (ena),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .cs_fs        (cs_fs),
        .tx_out       (tx_out),
        .frame_cnt    (frame_cnt),
        .underrun     (underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic exp_c(input logic [7:0] f);
        logic [3:0] fs;
        logic [3:0] wl;
        logic       b;
        fs = 4'b0010;
        wl = 4'b1011;
        b  = 1'b0;
        if (f == 8'd2) b = 1'b1;
        if (f >= 8'd24 && f <= 8'd27) b = fs[2'(f - 8'd24)];
        if (f >= 8'd32 && f <= 8'd35) b = wl[2'(f - 8'd32)];
`ifdef SPDIF_TX_CHSTAT_EN
        return b;
`else
        return b & 1'b0;
`endif
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (sample_ready !== 1'b1 && n < 8 * 128 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        if (sample_ready !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout: observed sample_ready=%b expected 1", sample_ready);
            finish_sim();
        end
    endtask

    // Samples each cell once and checks it stays put for CLK_DIV clocks with no stray strobes.
    task automatic capture_frame(output logic [127:0] c);
        int bad;
        bad = 0;
        c = '0;
        for (int k = 0; k < 128; k++) begin
            for (int j = 0; j < ((k == 127) ? CLK_DIV - 1 : CLK_DIV); j++) begin
                @(negedge clk);
                if (j == 0) c[k] = tx_out;
                else if (tx_out !== c[k]) bad++;
                if (sample_ready !== 1'b0 || underrun !== 1'b0) bad++;
                if (k == 10 && j == 0) begin
                    sample_l     = 24'($urandom);
                    sample_r     = 24'($urandom);
                    sample_valid = 1'($urandom_range(0, 1));
                end
            end
        end
        chk("cell_width", 32'(bad), 32'd0);
    endtask

    task automatic decode_sub(input logic [63:0] c, input logic p, input logic [7:0] pat,
                              input logic [23:0] ed, input logic ev, input logic ec,
                              input string tag);
        logic [7:0]  pre;
        logic [31:0] bits;
        logic        prv;
        int          tbad;
        bits = '0;
        tbad = 0;
        for (int k = 0; k < 8; k++) pre[7-k] = c[k] ^ p;
        prv = c[7];
        for (int s = 4; s < 32; s++) begin
            if (c[2*s] === prv) tbad++;
            bits[s] = c[2*s] ^ c[2*s+1];
            prv = c[2*s+1];
        end
        chk({tag, "_preamble"}, 32'(pre), 32'(pat));
        chk({tag, "_data"}, 32'(bits[27:4]), 32'(ed));
        chk({tag, "_v"}, 32'(bits[28]), 32'(ev));
        chk({tag, "_u"}, 32'(bits[29]), 32'd0);
        chk({tag, "_c"}, 32'(bits[30]), 32'(ec));
        chk({tag, "_parity"}, 32'(^bits), 32'd0);
        chk({tag, "_slot_edges"}, 32'(tbad), 32'd0);
    endtask

    task automatic frame_step(input logic vld, input logic [23:0] l, input logic [23:0] r);
        exp_t e;
        sample_l     = l;
        sample_r     = r;
        sample_valid = vld;
        wait_ready();
        chk("underrun", 32'(underrun), 32'(!vld));
        e.l     = vld ? l : 24'd0;
        e.r     = vld ? r : 24'd0;
        e.v     = !vld;
        e.frame = 8'(model_frame);
        sb.push_back(e);
        @(posedge clk);
        capture_frame(cells);
        e = sb.pop_front();
        chk("frame_cnt", 32'(frame_cnt), 32'(e.frame));
        decode_sub(cells[63:0], last_lvl, (e.frame == 8'd0) ? PRE_B : PRE_M,
                   e.l, e.v, exp_c(e.frame), "left");
        decode_sub(cells[127:64], cells[63], PRE_W, e.r, e.v, exp_c(e.frame), "right");
        last_lvl    = cells[127];
        model_frame = (model_frame == 191) ? 0 : model_frame + 1;
    endtask

    initial begin
        resetb = 1'b0; ena = 1'b0; sample_l = '0; sample_r = '0; sample_valid = 1'b0;
        cs_fs  = 4'b0010;
        repeat (3) @(negedge clk);
        chk("reset_tx_out", 32'(tx_out), 32'd0);
        chk("reset_ready", 32'(sample_ready), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);

        resetb = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_tx_out", 32'(tx_out), 32'd0);
        chk("idle_ready", 32'(sample_ready), 32'd0);

        // Enable and first valid pair rise together.
        model_frame = 0;
        last_lvl    = 1'b0;
        ena         = 1'b1;
        frame_step(1'b1, 24'h123456, 24'hABCDEF);
        frame_step(1'b1, 24'hFFFFFF, 24'h800000);
        frame_step(1'b1, 24'h000000, 24'h000001);
        for (int i = 0; i < 3; i++) frame_step(1'b0, 24'h5A5A5A, 24'hA5A5A5);
        for (int i = 6; i < 193; i++)
            frame_step((i % 17) != 0, 24'($urandom), 24'($urandom));

        // Abort at cell 70 of frame 1.
        sample_l = 24'h111111; sample_r = 24'h222222; sample_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        repeat (70 * CLK_DIV + 1) @(negedge clk);
        chk("pre_abort_frame_cnt", 32'(frame_cnt), 32'd1);
        ena = 1'b0;
        @(negedge clk);
        chk("abort_tx_out", 32'(tx_out), 32'd0);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("abort_ready", 32'(sample_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_hold_tx_out", 32'(tx_out), 32'd0);

        model_frame = 0;
        last_lvl    = 1'b0;
        ena         = 1'b1;
        frame_step(1'b1, 24'h0F0F0F, 24'hF0F0F0);
        frame_step(1'b0, 24'h333333, 24'h444444);
        frame_step(1'b1, 24'h7FFFFF, 24'h800001);

        finish_sim();
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no completion expected finish before 3 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
